vliw_hazard_scoreboard: RTL and testbench
=========================================

// Module: vliw_hazard_scoreboard
// PURPOSE
//  Parametrised hazard unit for the N-slot VLIW pipeline, sitting between IF/ID and ID/EX.
//  A per-register scoreboard tracks in-flight loads with a configurable load-use latency.
//  The unit stalls a dependent bundle for exactly the remaining cycles.
//  A taken branch squashes wrong-path bundles for a programmable penalty; stall cycles are counted.
// PARAMETERS
//  SLOTS       2   issue slots per bundle
//  SRCS        2   source operands per slot
//  REG_W       3   register index width; NREGS = 2**REG_W
//  LOAD_LAT    2   stall cycles owed by a bundle issued directly after a load that writes its source
//  BR_PENALTY  2   cycles IF/ID is flushed after branch_taken (>=1)
//  R0_ZERO     0   1: register 0 never creates a hazard
// PORTS
//  clk              in   1                  rising-edge clock
//  reset            in   1                  async, active-high
//  id_valid         in   1                  IF/ID holds a real bundle
//  id_src           in   SLOTS*SRCS*REG_W   source indices; slot s, operand k at [(s*SRCS+k)*REG_W +: REG_W]
//  id_src_vld       in   SLOTS*SRCS         operand k of slot s is used
//  id_dst           in   SLOTS*REG_W        destination index per slot
//  id_is_load       in   SLOTS              slot is a load writing id_dst
//  branch_taken     in   1                  EX resolved a taken branch this cycle
//  control_mux      out  1                  0 = inject bubble (zero controls) into ID/EX
//  pc_write         out  1                  0 = hold PC
//  if_id_write      out  1                  0 = hold IF/ID
//  if_id_flush      out  1                  1 = clear IF/ID to NOP
//  stall_count      out  16                 saturating count of load-use stall cycles
// BEHAVIOUR
//  Reset (async): all scoreboard counters = 0; flush counter = 0; stall_count = 0.
//  Outputs while reset is high and directly after it: control_mux=1, pc_write=1, if_id_write=1, if_id_flush=0.
//  Scoreboard:
//   - One counter per register, width $clog2(LOAD_LAT+1).
//   - A register is busy while its counter is non-zero.
//   - Every cycle, every non-zero counter decrements by 1.
//  Hazard (combinational):
//   - hz = id_valid AND some operand with id_src_vld=1 names a busy register.
//   - When R0_ZERO=1, register 0 is excluded from this check.
//   - Operands are checked across all slots.
//  Issue:
//   - issue = id_valid & !hz & !flush_active.
//   - On issue, each slot with id_is_load=1 loads its id_dst counter with LOAD_LAT at the clock edge.
//   - When set and decrement hit the same register in the same cycle, set wins.
//   - Two slots loading the same register set it once, to LOAD_LAT.
//   - A load to an already-busy register reloads LOAD_LAT.
//   - Stalled or squashed bundles never update the scoreboard.
//  Timing: a load issues in cycle t; a dependent bundle in ID at t+1 stalls for cycles t+1..t+LOAD_LAT and issues at t+LOAD_LAT+1.
//  Stall (hz & !flush_active): control_mux=0, pc_write=0, if_id_write=0, if_id_flush=0; stall_count += 1, saturating at 16'hFFFF.
//  Branch flush:
//   - flush_active = branch_taken | (flush_cnt != 0).
//   - On branch_taken, flush_cnt loads BR_PENALTY-1; otherwise it decrements while non-zero.
//   - While flush_active: control_mux=0, pc_write=1 (PC takes the target), if_id_write=1, if_id_flush=1.
//   - stall_count does not increment during a flush.
//  Priority: flush beats stall. A branch arriving during an active flush restarts flush_cnt. Scoreboard counters keep decrementing during a flush.
//  Idle (no hz, no flush): control_mux=1, pc_write=1, if_id_write=1, if_id_flush=0.
//  Reset asserted mid-stall or mid-flush clears all state immediately; the next cycle is idle.
//  All outputs are combinational from registered state and current inputs; no added latency.
// TESTING
//  T1 LOAD_LAT=2: load r3 in slot0 issues; next bundle reads r3 in slot1 -> control_mux=0 for 2 cycles, issue on 3rd; stall_count=2.
//  T2 load r5 issues, then an unrelated bundle, then a reader of r5 -> 1 stall cycle (counter at 1); with LOAD_LAT=1, 0 stalls.
//  T3 branch_taken pulse during a load-use stall, BR_PENALTY=2 -> if_id_flush=1 and pc_write=1 for 2 cycles; stall_count frozen.
//  T4 R0_ZERO=1: load writes r0, next bundle reads r0 -> no stall; with R0_ZERO=0 -> stall of LOAD_LAT.
//  T5 both slots load r2 in one bundle, then 2nd load r2 one cycle later -> r2 counter reloads to LOAD_LAT; reader stalls accordingly.
//  T6 reset asserted mid-flush and mid-stall -> outputs idle immediately, stall_count=0; force 70000 stalls -> stall_count holds 16'hFFFF.

Source files
------------

// File: rtl/vliw_hazard_scoreboard.sv
// Hazard unit for an N-slot VLIW pipeline between IF/ID and ID/EX.
// A per-register countdown scoreboard tracks in-flight loads. A bundle that
// reads a busy register stalls until that register's counter reaches zero.
// A taken branch squashes IF/ID for BR_PENALTY cycles, and the flush takes
// priority over a stall. The number of load-use stall cycles is counted and
// the count saturates.
module vliw_hazard_scoreboard #(
  parameter int SLOTS      = 2,
  parameter int SRCS       = 2,
  parameter int REG_W      = 3,
  parameter int LOAD_LAT   = 2,
  parameter int BR_PENALTY = 2,
  parameter int R0_ZERO    = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         id_valid,
  input  logic [SLOTS*SRCS*REG_W-1:0]  id_src,
  input  logic [SLOTS*SRCS-1:0]        id_src_vld,
  input  logic [SLOTS*REG_W-1:0]       id_dst,
  input  logic [SLOTS-1:0]             id_is_load,
  input  logic                         branch_taken,
  output logic                         control_mux,
  output logic                         pc_write,
  output logic                         if_id_write,
  output logic                         if_id_flush,
  output logic [15:0]                  stall_count
);

  localparam int NREGS = 2**REG_W;
  localparam int NOPS  = SLOTS*SRCS;
  localparam int CW    = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT+1);
  localparam int FW    = $clog2(BR_PENALTY+1);

  logic [NREGS-1:0][CW-1:0] r_sb_cnt;
  logic [FW-1:0]            r_flush_cnt;
  logic [15:0]              r_stall_cnt;

  logic [NREGS-1:0] w_busy;
  logic [NREGS-1:0] w_set;
  logic             w_src_hit;
  logic             w_hz;
  logic             w_flush_active;
  logic             w_stall;
  logic             w_issue;

  // Busy map: a register with a non-zero counter. R0 can be hardwired clean.
  always_comb begin
    for (int r = 0; r < NREGS; r++) w_busy[r] = (r_sb_cnt[r] != '0);
    if (R0_ZERO != 0) w_busy[0] = 1'b0;
  end

  // Hazard check. Every used operand of every slot is tested against the busy map.
  always_comb begin
    w_src_hit = 1'b0;
    for (int k = 0; k < NOPS; k++)
      if (id_src_vld[k] && w_busy[id_src[k*REG_W +: REG_W]]) w_src_hit = 1'b1;
  end

  // Reset gates the flush and stall terms, so the outputs read idle while reset is held.
  assign w_flush_active = !reset && (branch_taken || (r_flush_cnt != '0));
  assign w_hz           = !reset && id_valid && w_src_hit;
  assign w_stall        = w_hz && !w_flush_active;
  assign w_issue        = !reset && id_valid && !w_hz && !w_flush_active;

  // Scoreboard set vector. Only issued load slots mark a destination busy.
  always_comb begin
    w_set = '0;
    for (int s = 0; s < SLOTS; s++)
      if (w_issue && id_is_load[s]) w_set[id_dst[s*REG_W +: REG_W]] = 1'b1;
  end

  // Per-register countdown. A fresh load reloads the full latency, and a set beats the decrement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sb_cnt <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (w_set[r])                r_sb_cnt[r] <= CW'(LOAD_LAT);
        else if (r_sb_cnt[r] != '0)  r_sb_cnt[r] <= r_sb_cnt[r] - CW'(1);
      end
    end
  end

  // Flush countdown. The branch cycle itself flushes; the counter covers the remaining cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    r_flush_cnt <= '0;
    else if (branch_taken)        r_flush_cnt <= FW'(BR_PENALTY-1);
    else if (r_flush_cnt != '0)   r_flush_cnt <= r_flush_cnt - FW'(1);
  end

  // Saturating count of load-use stall cycles. Flush cycles are not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  r_stall_cnt <= '0;
    else if (w_stall && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_count = r_stall_cnt;

  // Pipeline controls: flush over stall over idle.
  always_comb begin
    control_mux = 1'b1;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    if (w_flush_active) begin
      control_mux = 1'b0;
      if_id_flush = 1'b1;
    end else if (w_stall) begin
      control_mux = 1'b0;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_vliw_hazard_scoreboard.sv
// Self-checking bench for vliw_hazard_scoreboard.
// dut1 uses the default parameters and runs the main vector table.
// dut2 uses LOAD_LAT=1 and R0_ZERO=1. dut3 uses LOAD_LAT=200 so that stall_count saturates within a short run.
module tb_vliw_hazard_scoreboard;

  localparam logic [3:0] IDLE = 4'b1110;  // {control_mux, pc_write, if_id_write, if_id_flush}
  localparam logic [3:0] STL  = 4'b0000;
  localparam logic [3:0] FLS  = 4'b0111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0;
  logic [11:0] id_src = '0;
  logic [3:0]  id_src_vld = '0;
  logic [5:0]  id_dst = '0;
  logic [1:0]  id_is_load = '0;
  logic        branch_taken = 1'b0;

  logic [3:0]  ctl1, ctl2, ctl3;
  logic [15:0] cnt1, cnt2, cnt3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vliw_hazard_scoreboard dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src), .id_src_vld(id_src_vld),
    .id_dst(id_dst), .id_is_load(id_is_load), .branch_taken(branch_taken),
    .control_mux(ctl1[3]), .pc_write(ctl1[2]), .if_id_write(ctl1[1]), .if_id_flush(ctl1[0]),
    .stall_count(cnt1));

  vliw_hazard_scoreboard #(.LOAD_LAT(1), .R0_ZERO(1)) dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src), .id_src_vld(id_src_vld),
    .id_dst(id_dst), .id_is_load(id_is_load), .branch_taken(branch_taken),
    .control_mux(ctl2[3]), .pc_write(ctl2[2]), .if_id_write(ctl2[1]), .if_id_flush(ctl2[0]),
    .stall_count(cnt2));

  vliw_hazard_scoreboard #(.LOAD_LAT(200)) dut3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src), .id_src_vld(id_src_vld),
    .id_dst(id_dst), .id_is_load(id_is_load), .branch_taken(branch_taken),
    .control_mux(ctl3[3]), .pc_write(ctl3[2]), .if_id_write(ctl3[1]), .if_id_flush(ctl3[0]),
    .stall_count(cnt3));

  typedef struct {
    logic        vld;
    logic [11:0] src;
    logic [3:0]  svld;
    logic [5:0]  dst;
    logic [1:0]  ld;
    logic        br;
    logic [3:0]  ctl;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    logic [3:0]  ctl;
    logic [15:0] cnt;
    int          idx;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  // Source field: {slot1 op1, slot1 op0, slot0 op1, slot0 op0}
  function automatic logic [11:0] s4(logic [2:0] a, logic [2:0] b, logic [2:0] c, logic [2:0] d);
    return {d, c, b, a};
  endfunction

  function automatic vec_t mk(logic v, logic [11:0] s, logic [3:0] sv, logic [5:0] d,
                              logic [1:0] l, logic b, logic [3:0] c, logic [15:0] n);
    vec_t x;
    x.vld = v; x.src = s; x.svld = sv; x.dst = d; x.ld = l; x.br = b; x.ctl = c; x.cnt = n;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [11:0] s, input logic [3:0] sv,
                     input logic [5:0] d, input logic [1:0] l, input logic b);
    @(posedge clk);
    #1;
    id_valid = v; id_src = s; id_src_vld = sv; id_dst = d; id_is_load = l; branch_taken = b;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    id_valid = 1'b0; id_src = '0; id_src_vld = '0; id_dst = '0; id_is_load = '0; branch_taken = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    exp_t e;
    // Reset state: outputs are idle even with a branch asserted during reset.
    branch_taken = 1'b1;
    #2;
    chk("reset_ctl", {12'd0, ctl1}, {12'd0, IDLE});
    chk("reset_cnt", cnt1, 16'd0);
    branch_taken = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Main table for dut1 (LOAD_LAT=2, BR_PENALTY=2, R0_ZERO=0)
    vt.push_back(mk(0, 12'd0,            4'b0000, {3'd0,3'd0}, 2'b00, 0, IDLE, 0)); // 0 idle
    vt.push_back(mk(1, 12'd0,            4'b0000, {3'd0,3'd3}, 2'b01, 0, IDLE, 0)); // 1 load r3
    vt.push_back(mk(1, s4(0,0,3,0),      4'b0100, 6'd0,        2'b00, 0, STL,  0)); // 2 slot1 reads r3
    vt.push_back(mk(1, s4(0,0,3,0),      4'b0100, 6'd0,        2'b00, 0, STL,  1)); // 3
    vt.push_back(mk(1, s4(0,0,3,0),      4'b0100, 6'd0,        2'b00, 0, IDLE, 2)); // 4 issues
    vt.push_back(mk(1, 12'd0,            4'b0000, {3'd5,3'd0}, 2'b10, 0, IDLE, 2)); // 5 load r5 slot1
    vt.push_back(mk(1, s4(1,0,0,0),      4'b0001, 6'd0,        2'b00, 0, IDLE, 2)); // 6 unrelated
    vt.push_back(mk(1, s4(5,0,0,0),      4'b0001, 6'd0,        2'b00, 0, STL,  2)); // 7 reader r5
    vt.push_back(mk(1, s4(5,0,0,0),      4'b0001, 6'd0,        2'b00, 0, IDLE, 3)); // 8
    vt.push_back(mk(1, 12'd0,            4'b0000, {3'd0,3'd3}, 2'b01, 0, IDLE, 3)); // 9 load r3
    vt.push_back(mk(1, s4(0,0,0,3),      4'b1000, 6'd0,        2'b00, 0, STL,  3)); // 10 stall
    vt.push_back(mk(1, s4(0,0,0,3),      4'b1000, 6'd0,        2'b00, 1, FLS,  4)); // 11 branch mid-stall
    vt.push_back(mk(1, s4(0,0,0,3),      4'b1000, 6'd0,        2'b00, 0, FLS,  4)); // 12
    vt.push_back(mk(1, s4(0,0,0,3),      4'b1000, 6'd0,        2'b00, 0, IDLE, 4)); // 13
    vt.push_back(mk(0, 12'd0,            4'b0000, 6'd0,        2'b00, 1, FLS,  4)); // 14 branch
    vt.push_back(mk(0, 12'd0,            4'b0000, 6'd0,        2'b00, 1, FLS,  4)); // 15 restart
    vt.push_back(mk(0, 12'd0,            4'b0000, 6'd0,        2'b00, 0, FLS,  4)); // 16
    vt.push_back(mk(0, 12'd0,            4'b0000, 6'd0,        2'b00, 0, IDLE, 4)); // 17
    vt.push_back(mk(1, 12'd0,            4'b0000, {3'd2,3'd2}, 2'b11, 0, IDLE, 4)); // 18 both slots load r2
    vt.push_back(mk(1, 12'd0,            4'b0000, {3'd0,3'd2}, 2'b01, 0, IDLE, 4)); // 19 reload r2
    vt.push_back(mk(1, s4(0,0,0,2),      4'b1000, 6'd0,        2'b00, 0, STL,  4)); // 20
    vt.push_back(mk(1, s4(0,0,0,2),      4'b1000, 6'd0,        2'b00, 0, STL,  5)); // 21
    vt.push_back(mk(1, s4(0,0,0,2),      4'b1000, 6'd0,        2'b00, 0, IDLE, 6)); // 22
    vt.push_back(mk(1, 12'd0,            4'b0000, {3'd0,3'd4}, 2'b01, 1, FLS,  6)); // 23 squashed load r4
    vt.push_back(mk(1, s4(4,0,0,0),      4'b0001, 6'd0,        2'b00, 0, FLS,  6)); // 24
    vt.push_back(mk(1, s4(4,0,0,0),      4'b0001, 6'd0,        2'b00, 0, IDLE, 6)); // 25 r4 clean
    vt.push_back(mk(1, 12'd0,            4'b0000, {3'd0,3'd6}, 2'b01, 0, IDLE, 6)); // 26 load r6
    vt.push_back(mk(1, s4(6,0,0,0),      4'b0001, {3'd0,3'd7}, 2'b01, 0, STL,  6)); // 27 stalled load r7
    vt.push_back(mk(1, s4(0,7,0,0),      4'b0010, 6'd0,        2'b00, 0, IDLE, 7)); // 28 r7 clean
    vt.push_back(mk(1, 12'd0,            4'b0000, 6'd0,        2'b01, 0, IDLE, 7)); // 29 load r0
    vt.push_back(mk(1, s4(0,0,0,0),      4'b0001, 6'd0,        2'b00, 0, STL,  7)); // 30 r0 reader
    vt.push_back(mk(1, s4(0,0,0,0),      4'b0001, 6'd0,        2'b00, 0, STL,  8)); // 31
    vt.push_back(mk(1, s4(0,0,0,0),      4'b0001, 6'd0,        2'b00, 0, IDLE, 9)); // 32
    vt.push_back(mk(1, 12'd0,            4'b0000, {3'd0,3'd1}, 2'b01, 0, IDLE, 9)); // 33 load r1
    vt.push_back(mk(0, s4(1,1,1,1),      4'b1111, 6'd0,        2'b00, 0, IDLE, 9)); // 34 not valid
    vt.push_back(mk(1, s4(1,1,1,1),      4'b0000, 6'd0,        2'b00, 0, IDLE, 9)); // 35 operands unused

    for (int i = 0; i < vt.size(); i++) begin
      drv(vt[i].vld, vt[i].src, vt[i].svld, vt[i].dst, vt[i].ld, vt[i].br);
      e.ctl = vt[i].ctl; e.cnt = vt[i].cnt; e.idx = i;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("vec%0d_ctl", e.idx), {12'd0, ctl1}, {12'd0, e.ctl});
      chk($sformatf("vec%0d_cnt", e.idx), cnt1, e.cnt);
    end

    // LOAD_LAT=1 and R0_ZERO=1 (dut2), contrasted with dut1
    do_reset();
    drv(1, 12'd0, 4'b0000, {3'd0,3'd5}, 2'b01, 0);       // load r5
    @(negedge clk); chk("d2_load_r5", {12'd0, ctl2}, {12'd0, IDLE});
    drv(1, 12'd0, 4'b0000, 6'd0, 2'b00, 0);              // unrelated
    @(negedge clk);
    drv(1, s4(5,0,0,0), 4'b0001, 6'd0, 2'b00, 0);        // reader r5
    @(negedge clk);
    chk("d2_gap_nostall", {12'd0, ctl2}, {12'd0, IDLE});
    chk("d1_gap_stall",   {12'd0, ctl1}, {12'd0, STL});
    drv(1, 12'd0, 4'b0000, 6'd0, 2'b01, 0);              // load r0
    @(negedge clk);
    drv(1, s4(0,0,0,0), 4'b0001, 6'd0, 2'b00, 0);        // reader r0
    @(negedge clk); chk("d2_r0_nostall", {12'd0, ctl2}, {12'd0, IDLE});
    drv(1, 12'd0, 4'b0000, {3'd0,3'd3}, 2'b01, 0);       // load r3
    @(negedge clk);
    drv(1, s4(3,0,0,0), 4'b0001, 6'd0, 2'b00, 0);        // reader r3
    @(negedge clk); chk("d2_lat1_stall", {12'd0, ctl2}, {12'd0, STL});
    drv(1, s4(3,0,0,0), 4'b0001, 6'd0, 2'b00, 0);
    @(negedge clk);
    chk("d2_lat1_issue", {12'd0, ctl2}, {12'd0, IDLE});
    chk("d2_stall_cnt", cnt2, 16'd1);

    // Reset asserted mid-stall
    do_reset();
    drv(1, 12'd0, 4'b0000, {3'd0,3'd3}, 2'b01, 0);
    drv(1, s4(3,0,0,0), 4'b0001, 6'd0, 2'b00, 0);
    @(negedge clk);
    drv(1, s4(3,0,0,0), 4'b0001, 6'd0, 2'b00, 0);
    @(negedge clk);
    chk("midstall_ctl", {12'd0, ctl1}, {12'd0, STL});
    chk("midstall_cnt", cnt1, 16'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_stall_ctl", {12'd0, ctl1}, {12'd0, IDLE});
    chk("rst_stall_cnt", cnt1, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_idle", {12'd0, ctl1}, {12'd0, IDLE});

    // Reset asserted mid-flush
    drv(0, 12'd0, 4'b0000, 6'd0, 2'b00, 1);
    @(negedge clk); chk("flush_c1", {12'd0, ctl1}, {12'd0, FLS});
    drv(0, 12'd0, 4'b0000, 6'd0, 2'b00, 0);
    @(negedge clk); chk("flush_c2", {12'd0, ctl1}, {12'd0, FLS});
    #1 reset = 1'b1;
    #1 chk("rst_flush_ctl", {12'd0, ctl1}, {12'd0, IDLE});
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 chk("post_rst_flush_idle", {12'd0, ctl1}, {12'd0, IDLE});

    // Saturation on dut3: a self-re-arming reader stalls 200 of every 201 cycles
    do_reset();
    drv(1, 12'd0, 4'b0000, {3'd0,3'd3}, 2'b01, 0);
    drv(1, s4(3,0,0,0), 4'b0001, {3'd0,3'd3}, 2'b01, 0);
    repeat (201*100) @(posedge clk);
    @(negedge clk); chk("sat_20000", cnt3, 16'd20000);
    repeat (201*226) @(posedge clk);
    @(negedge clk); chk("sat_65200", cnt3, 16'd65200);
    repeat (201*2) @(posedge clk);
    @(negedge clk); chk("sat_ffff", cnt3, 16'hFFFF);
    repeat (201) @(posedge clk);
    @(negedge clk); chk("sat_hold", cnt3, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
